// File: rtl/wavelet_fir_dec_if.sv
// Sample, coefficient and result signals of the wavelet analysis filter pair.
interface wavelet_fir_dec_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4
);
  localparam int AW = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic                     coef_sel;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     flush;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_lo;
  logic signed [DATA_W-1:0] out_hi;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, coef_we, coef_sel, coef_addr, coef_data, flush,
    input  out_valid, out_lo, out_hi, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_sel, coef_addr, coef_data, flush,
    output out_valid, out_lo, out_hi, out_sat
  );
endinterface

// File: rtl/wavelet_fir_dec.sv
// Signed lo/hi analysis FIR pair with loadable coefficients, round-half-up,
// saturation, warm-up suppression, flush and optional decimate-by-2.
module wavelet_fir_dec #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4,
  parameter int FRAC   = 8,
  parameter int DECIM  = 1
) (
  input logic             clk,
  input logic             rst_n,
  wavelet_fir_dec_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int FW    = $clog2(TAPS + 1);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Only TAPS-1 past samples are stored; tap 0 is the sample being accepted.
  logic signed [DATA_W-1:0] win     [TAPS-1];
  logic signed [DATA_W-1:0] tap     [TAPS];
  logic signed [COEF_W-1:0] coef_lo [TAPS];
  logic signed [COEF_W-1:0] coef_hi [TAPS];
  logic signed [PW-1:0]     prod_lo [TAPS];
  logic signed [PW-1:0]     prod_hi [TAPS];
  logic signed [ACC_W-1:0]  acc_lo, acc_hi, rnd_lo, rnd_hi;
  logic [FW-1:0]            fill;
  logic                     phase;
  logic                     s1_valid;
  logic                     accept;
  logic                     emit;
  logic                     sat_lo, sat_hi;

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V) return MAX_V[DATA_W-1:0];
    if (v < MIN_V) return MIN_V[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  assign accept = bus.in_valid && !bus.flush;
  assign emit   = accept && (fill >= FW'(TAPS - 1)) && ((DECIM == 0) || phase);

  always_comb begin
    tap[0] = bus.in_data;
    for (int k = 1; k < TAPS; k++) tap[k] = win[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS - 1; k++) win[k] <= '0;
      fill  <= '0;
      phase <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < TAPS - 1; k++) win[k] <= '0;
      fill  <= '0;
      phase <= 1'b0;
    end else if (bus.in_valid) begin
      win[0] <= bus.in_data;
      for (int k = 1; k < TAPS - 1; k++) win[k] <= win[k-1];
      if (fill != FW'(TAPS)) fill <= fill + FW'(1);
      phase <= ~phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_lo[k] <= '0;
        coef_hi[k] <= '0;
      end
    end else if (bus.coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (bus.coef_addr == AW'(k)) begin
          if (bus.coef_sel) coef_hi[k] <= bus.coef_data;
          else              coef_lo[k] <= bus.coef_data;
        end
      end
    end
  end

  // Products use the registered coefficients, so a same-cycle write lands one sample later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        prod_lo[k] <= '0;
        prod_hi[k] <= '0;
      end
    end else begin
      s1_valid <= emit;
      if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          prod_lo[k] <= PW'(tap[k]) * PW'(coef_lo[k]);
          prod_hi[k] <= PW'(tap[k]) * PW'(coef_hi[k]);
        end
      end
    end
  end

  always_comb begin
    acc_lo = '0;
    acc_hi = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_lo = acc_lo + ACC_W'(prod_lo[k]);
      acc_hi = acc_hi + ACC_W'(prod_hi[k]);
    end
    rnd_lo = (acc_lo + HALF) >>> FRAC;
    rnd_hi = (acc_hi + HALF) >>> FRAC;
    sat_lo = (rnd_lo > MAX_V) || (rnd_lo < MIN_V);
    sat_hi = (rnd_hi > MAX_V) || (rnd_hi < MIN_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_lo    <= '0;
      bus.out_hi    <= '0;
      bus.out_sat   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_lo <= clamp(rnd_lo);
        bus.out_hi <= clamp(rnd_hi);
        if (sat_lo || sat_hi) bus.out_sat <= 1'b1;
      end
    end
  end
endmodule
